instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register plus a two-state IDLE/REQ fetch handshake with instruction memory.
// Optional fetch timeout is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_enable,
    input  logic        pc_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic        fetch_busy,
    output logic        fetch_ovr,
    output logic        fetch_err
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;
    logic   start;
    logic   done;
    logic   expire;
    logic   timeout_hit;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        done       = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (if_enable) begin
                    start      = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                // A completing ack beats a timeout landing on the same edge.
                if (imem_ack) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_addr   <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            pc          <= RESET_PC;
            fetch_ovr   <= 1'b0;
        end else begin
            fetch_ovr <= (state == REQ) && if_enable;
            if (start) begin
                imem_addr   <= pc;
                instr_valid <= 1'b0;
            end
            if (done) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            if (expire) begin
                instr       <= '0;
                instr_valid <= 1'b1;
            end
            if (pc_write) begin
                pc <= branch_taken ? (branch_target & 32'hFFFF_FFFC) : pc + 32'd4;
            end
        end
    end

    assign imem_req   = (state == REQ);
    assign fetch_busy = (state == REQ);

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] tmo_cnt;

    // Counts completed REQ cycles; expiry fires on the TIMEOUT_CYC-th edge spent waiting.
    assign timeout_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt   <= '0;
            fetch_err <= 1'b0;
        end else begin
            if ((state == REQ) && (state_next == REQ)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
            if (expire) begin
                fetch_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

endmodule
